counter_cmd_sched: RTL

- Shared-counter scheduler: arbitrates increment, decrement, clear and load commands from NREQ host-side requesters plus an internal autocount prescaler onto one W-bit counter.
- Emits single-cycle event pulses (wrap, match, dropped tick) for trigger-out endpoints.
- Sits between wire/trigger-in endpoint logic and the wire-out/trigger-out endpoints, all in the sys_clk domain.

---
 rtl/counter_cmd_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/counter_cmd_sched.sv
// -----------------------------------------------------------------------------
// counter_cmd_sched
//
// Shared-counter scheduler. Round-robin arbitration picks one host command
// (inc / dec / clear / load) per cycle and applies it to a single W-bit
// counter. An internal prescaler generates autocount ticks. A tick is held
// in auto_pending and executes as an inc only in a cycle with no host
// request. Single-cycle registered event pulses report wrap/clamp, match
// and lost ticks.
//
// Ports
//   sys_clk        clock, all logic on rising edge
//   reset          synchronous active-high reset
//   req_valid      per-requester command valid            [NREQ]
//   req_op         per-requester op, requester i at [2i+:2]
//                  (00 inc, 01 dec, 10 clear, 11 load)
//   req_data       per-requester load value at [Wi+:W]
//   req_ready      one-hot grant (combinational, same cycle)
//   auto_en        enable prescaler-driven autocount
//   div_value      prescaler reload; tick period div_value+1 cycles
//   match_value    compare value for evt_match
//   count          registered counter value
//   grant_id       index of the last granted host requester
//   evt_wrap       pulse on wrap, or on a clamp attempt when SATURATE=1
//   evt_match      pulse when an executed command moves count onto match_value
//   evt_tick_drop  pulse when an auto tick is lost
// -----------------------------------------------------------------------------
module counter_cmd_sched #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int DIVW     = 24,
    parameter int SATURATE = 0
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                auto_en,
    input  logic [DIVW-1:0]     div_value,
    input  logic [W-1:0]        match_value,
    output logic [W-1:0]        count,
    output logic [2:0]          grant_id,
    output logic                evt_wrap,
    output logic                evt_match,
    output logic                evt_tick_drop
);

    localparam logic [1:0]      OP_INC  = 2'b00;
    localparam logic [1:0]      OP_DEC  = 2'b01;
    localparam logic [1:0]      OP_CLR  = 2'b10;
    localparam logic [1:0]      OP_LOAD = 2'b11;
    localparam logic [W-1:0]    CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0]    CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0]    CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [DIVW-1:0] PRE_ZERO = {DIVW{1'b0}};
    localparam logic [DIVW-1:0] PRE_ONE  = {{(DIVW-1){1'b0}}, 1'b1};
    localparam logic            SAT_EN   = (SATURATE != 0) ? 1'b1 : 1'b0;

    logic [2:0]      ptr_r;
    logic [DIVW-1:0] presc_r;
    logic            auto_pending_r;

    logic            found_s;
    logic [2:0]      win_s;
    logic [3:0]      dist_s;
    logic [3:0]      best_dist_s;
    logic [1:0]      op_s;
    logic [W-1:0]    data_s;
    logic            xfer_s;
    logic            svc_s;
    logic            tick_s;
    logic            exec_s;
    logic [1:0]      exec_op_s;
    logic [W-1:0]    next_cnt_s;
    logic            wrap_s;

    // Round-robin pick: the valid requester closest to ptr_r (modulo NREQ) wins.
    always_comb begin
        found_s     = 1'b0;
        win_s       = 3'd0;
        dist_s      = 4'd0;
        best_dist_s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (4'(i) >= {1'b0, ptr_r}) begin
                dist_s = 4'(i) - {1'b0, ptr_r};
            end else begin
                dist_s = 4'(i) + 4'(NREQ) - {1'b0, ptr_r};
            end
            if (req_valid[i] && (!found_s || (dist_s < best_dist_s))) begin
                found_s     = 1'b1;
                win_s       = 3'(i);
                best_dist_s = dist_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // One-hot ready plus the winner's op/data slice; nothing is granted in reset.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        op_s      = OP_INC;
        data_s    = CNT_ZERO;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = found_s && !reset && (win_s == 3'(i));
            if (win_s == 3'(i)) begin
                op_s   = req_op[2*i +: 2];
                data_s = req_data[W*i +: W];
            end else begin
                op_s   = op_s;
            end
        end
    end

    assign xfer_s = found_s & ~reset;
    // Autocount is lowest priority: any asserted valid bit blocks it.
    assign svc_s  = auto_pending_r & ~(|req_valid);
    assign tick_s = auto_en & (presc_r == PRE_ZERO);

    // Next counter value and bound detection for the executed command.
    always_comb begin
        exec_s     = xfer_s | svc_s;
        exec_op_s  = xfer_s ? op_s : OP_INC;
        next_cnt_s = count;
        wrap_s     = 1'b0;
        if (exec_s) begin
            case (exec_op_s)
                OP_INC: begin
                    if (count == CNT_MAX) begin
                        wrap_s     = 1'b1;
                        next_cnt_s = SAT_EN ? count : CNT_ZERO;
                    end else begin
                        next_cnt_s = count + CNT_ONE;
                    end
                end
                OP_DEC: begin
                    if (count == CNT_ZERO) begin
                        wrap_s     = 1'b1;
                        next_cnt_s = SAT_EN ? count : CNT_MAX;
                    end else begin
                        next_cnt_s = count - CNT_ONE;
                    end
                end
                OP_CLR:  next_cnt_s = CNT_ZERO;
                OP_LOAD: next_cnt_s = data_s;
                default: next_cnt_s = count;
            endcase
        end else begin
            next_cnt_s = count;
        end
    end

    // Counter, grant bookkeeping and wrap/match events.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count     <= CNT_ZERO;
            grant_id  <= 3'd0;
            ptr_r     <= 3'd0;
            evt_wrap  <= 1'b0;
            evt_match <= 1'b0;
        end else begin
            count     <= next_cnt_s;
            evt_wrap  <= wrap_s;
            // Only a real value change onto match_value counts.
            evt_match <= exec_s && (next_cnt_s != count) && (next_cnt_s == match_value);
            if (xfer_s) begin
                grant_id <= win_s;
                ptr_r    <= (win_s == 3'(NREQ - 1)) ? 3'd0 : (win_s + 3'd1);
            end
        end
    end

    // Prescaler: reloads at zero (so a new div_value lands at reload), holds when disabled.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            presc_r <= div_value;
        end else if (auto_en) begin
            if (presc_r == PRE_ZERO) begin
                presc_r <= div_value;
            end else begin
                presc_r <= presc_r - PRE_ONE;
            end
        end
    end

    // Pending autocount: a tick colliding with service re-arms; a tick on an unserviced pending is lost.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            auto_pending_r <= 1'b0;
            evt_tick_drop  <= 1'b0;
        end else begin
            evt_tick_drop <= 1'b0;
            if (!auto_en) begin
                auto_pending_r <= 1'b0;
            end else if (tick_s) begin
                auto_pending_r <= 1'b1;
                evt_tick_drop  <= auto_pending_r & ~svc_s;
            end else if (svc_s) begin
                auto_pending_r <= 1'b0;
            end
        end
    end

endmodule
